// File: rtl/player_motion_ctrl.sv
// Player movement sequencer: arbitrates the button code, merges rectangle blocking flags,
// and owns the player position/colour registers with hold-to-repeat stepping.
module player_motion_ctrl #(
    parameter int NUM_RECT      = 8,
    parameter int PW            = 12,
    parameter int PH            = 12,
    parameter int H_INIT        = 314,
    parameter int V_INIT        = 234,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 2,
    parameter int NUM_COLORS    = 4
) (
    input  logic                btnClk,
    input  logic                rst,
    input  logic [3:0]          btns,
    input  logic                color_btn,
    input  logic [NUM_RECT-1:0] up_block,
    input  logic [NUM_RECT-1:0] down_block,
    input  logic [NUM_RECT-1:0] left_block,
    input  logic [NUM_RECT-1:0] right_block,
    output logic [9:0]          player_hPos,
    output logic [9:0]          player_vPos,
    output logic [3:0]          player_color,
    output logic                step_pulse,
    output logic                blocked_pulse,
    output logic                busy
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [9:0]    H_MAX       = 10'(640 - PW);
    localparam logic [9:0]    V_MAX       = 10'(480 - PH);
    localparam logic [9:0]    H_RESET     = 10'(H_INIT);
    localparam logic [9:0]    V_RESET     = 10'(V_INIT);
    localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);
    localparam logic [3:0]    COLOR_LAST  = 4'(NUM_COLORS - 1);

    localparam logic [3:0] BTN_UP    = 4'd8;
    localparam logic [3:0] BTN_DOWN  = 4'd4;
    localparam logic [3:0] BTN_RIGHT = 4'd2;
    localparam logic [3:0] BTN_LEFT  = 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        SETTLE,
        WAIT
    } state_t;

    state_t        state, stateNext;
    logic [3:0]    dirQ, dirNext;
    logic          firstQ, firstNext;
    logic [CW-1:0] cnt, cntNext;
    logic [9:0]    hPosNext, vPosNext;
    logic          stepNext, blockedNext;
    logic          cbtnQ;

    logic upBlocked, downBlocked, leftBlocked, rightBlocked;
    logic reqValid, canMove;

    assign upBlocked    = |up_block;
    assign downBlocked  = |down_block;
    assign leftBlocked  = |left_block;
    assign rightBlocked = |right_block;

    assign reqValid = (btns == BTN_UP) || (btns == BTN_DOWN) ||
                      (btns == BTN_RIGHT) || (btns == BTN_LEFT);

    // Bounds are against elaboration-time constants, so the 10-bit subtract never underflows.
    always_comb begin
        canMove = 1'b0;
        case (dirQ)
            BTN_UP:    canMove = !upBlocked    && (player_vPos != '0);
            BTN_DOWN:  canMove = !downBlocked  && (player_vPos < V_MAX);
            BTN_LEFT:  canMove = !leftBlocked  && (player_hPos != '0);
            BTN_RIGHT: canMove = !rightBlocked && (player_hPos < H_MAX);
            default:   canMove = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        stateNext   = state;
        dirNext     = dirQ;
        firstNext   = firstQ;
        cntNext     = cnt;
        hPosNext    = player_hPos;
        vPosNext    = player_vPos;
        stepNext    = 1'b0;
        blockedNext = 1'b0;

        case (state)
            IDLE: begin
                if (reqValid) begin
                    dirNext   = btns;
                    firstNext = 1'b1;
                    stateNext = STEP;
                end
            end
            STEP: begin
                if (canMove) begin
                    stepNext = 1'b1;
                    case (dirQ)
                        BTN_UP:    vPosNext = player_vPos - 10'd1;
                        BTN_DOWN:  vPosNext = player_vPos + 10'd1;
                        BTN_LEFT:  hPosNext = player_hPos - 10'd1;
                        BTN_RIGHT: hPosNext = player_hPos + 10'd1;
                        default:   ;
                    endcase
                end else begin
                    blockedNext = 1'b1;
                end
                stateNext = SETTLE;
            end
            SETTLE: begin
                if (btns == dirQ) begin
                    cntNext   = firstQ ? DELAY_LOAD : PERIOD_LOAD;
                    firstNext = 1'b0;
                    stateNext = WAIT;
                end else begin
                    stateNext = IDLE;
                end
            end
            WAIT: begin
                if (btns != dirQ) begin
                    stateNext = IDLE;
                end else if (cnt == '0) begin
                    stateNext = STEP;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dirQ          <= '0;
            firstQ        <= 1'b0;
            cnt           <= '0;
            player_hPos   <= H_RESET;
            player_vPos   <= V_RESET;
            step_pulse    <= 1'b0;
            blocked_pulse <= 1'b0;
        end else begin
            state         <= stateNext;
            dirQ          <= dirNext;
            firstQ        <= firstNext;
            cnt           <= cntNext;
            player_hPos   <= hPosNext;
            player_vPos   <= vPosNext;
            step_pulse    <= stepNext;
            blocked_pulse <= blockedNext;
        end
    end

    // Colour advances on each rising edge of color_btn, independent of the movement FSM.
    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            cbtnQ        <= 1'b0;
            player_color <= '0;
        end else begin
            cbtnQ <= color_btn;
            if (color_btn && !cbtnQ) begin
                player_color <= (player_color == COLOR_LAST) ? 4'd0 : player_color + 4'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: stepping latency, auto-repeat spacing, blocking,
// edge saturation, request filtering, colour cycling and asynchronous reset.
module tb_player_motion_ctrl;

    logic       btnClk;
    logic       rst;
    logic [3:0] btns;
    logic       color_btn;
    logic [7:0] up_block, down_block, left_block, right_block;
    logic [9:0] player_hPos, player_vPos;
    logic [3:0] player_color;
    logic       step_pulse, blocked_pulse, busy;

    int checks = 0;
    int errors = 0;

    player_motion_ctrl dut (
        .btnClk        (btnClk),
        .rst           (rst),
        .btns          (btns),
        .color_btn     (color_btn),
        .up_block      (up_block),
        .down_block    (down_block),
        .left_block    (left_block),
        .right_block   (right_block),
        .player_hPos   (player_hPos),
        .player_vPos   (player_vPos),
        .player_color  (player_color),
        .step_pulse    (step_pulse),
        .blocked_pulse (blocked_pulse),
        .busy          (busy)
    );

    initial btnClk = 1'b0;
    always #5 btnClk = ~btnClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge btnClk);
        #1;
    endtask

    initial begin
        int n;
        int nb;
        int ns;

        rst = 1'b1;
        btns = 4'd0;
        color_btn = 1'b0;
        up_block = '0;
        down_block = '0;
        left_block = '0;
        right_block = '0;
        #2;
        check("rst_hpos", player_hPos, 314);
        check("rst_vpos", player_vPos, 234);
        check("rst_color", player_color, 0);
        check("rst_step", step_pulse, 0);
        check("rst_blocked", blocked_pulse, 0);
        check("rst_busy", busy, 0);
        tick(2);
        rst = 1'b0;

        // Single right press held for one cycle.
        btns = 4'd2;
        tick(1);
        btns = 4'd0;
        check("r1_busy_accept", busy, 1);
        check("r1_hpos_before", player_hPos, 314);
        tick(1);
        check("r1_hpos", player_hPos, 315);
        check("r1_vpos", player_vPos, 234);
        check("r1_step", step_pulse, 1);
        check("r1_noblk", blocked_pulse, 0);
        tick(1);
        check("r1_step_low", step_pulse, 0);
        check("r1_idle", busy, 0);

        // Held down: steps at t, t+10, t+14, t+18.
        btns = 4'd4;
        tick(2);
        check("d_t0_vpos", player_vPos, 235);
        check("d_t0_step", step_pulse, 1);
        tick(9);
        check("d_t9_step", step_pulse, 0);
        check("d_t9_vpos", player_vPos, 235);
        tick(1);
        check("d_t10_vpos", player_vPos, 236);
        check("d_t10_step", step_pulse, 1);
        tick(3);
        check("d_t13_step", step_pulse, 0);
        tick(1);
        check("d_t14_vpos", player_vPos, 237);
        tick(3);
        check("d_t17_step", step_pulse, 0);
        tick(1);
        check("d_t18_vpos", player_vPos, 238);
        check("d_t18_step", step_pulse, 1);
        btns = 4'd0;
        tick(1);
        check("d_release_idle", busy, 0);

        // Held up while blocked by rectangle 5, then unblocked mid-WAIT.
        up_block[5] = 1'b1;
        btns = 4'd8;
        tick(2);
        check("u_t0_blocked", blocked_pulse, 1);
        check("u_t0_step", step_pulse, 0);
        check("u_t0_vpos", player_vPos, 238);
        tick(10);
        check("u_t10_blocked", blocked_pulse, 1);
        check("u_t10_vpos", player_vPos, 238);
        tick(1);
        up_block[5] = 1'b0;
        tick(2);
        check("u_t13_blocked", blocked_pulse, 0);
        tick(1);
        check("u_t14_vpos", player_vPos, 237);
        check("u_t14_step", step_pulse, 1);
        check("u_t14_noblk", blocked_pulse, 0);
        btns = 4'd0;
        tick(1);
        check("u_release_idle", busy, 0);

        // Invalid codes in IDLE are ignored.
        btns = 4'd6;
        tick(2);
        check("inv6_busy", busy, 0);
        check("inv6_hpos", player_hPos, 315);
        btns = 4'd0;
        tick(2);
        check("inv0_busy", busy, 0);

        // Direction change 4 -> 2 during WAIT.
        btns = 4'd4;
        tick(2);
        check("chg_vpos", player_vPos, 238);
        tick(1);
        btns = 4'd2;
        tick(1);
        check("chg_to_idle", busy, 0);
        tick(1);
        check("chg_accept", busy, 1);
        tick(1);
        check("chg_hpos", player_hPos, 316);
        check("chg_step", step_pulse, 1);
        btns = 4'd0;
        tick(1);

        // Walk right to the edge, then confirm saturation.
        btns = 4'd2;
        n = 0;
        while (player_hPos != 10'd628 && n < 3000) begin
            tick(1);
            n++;
        end
        check("edge_r_reach", player_hPos, 628);
        nb = 0;
        ns = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (blocked_pulse) nb++;
            if (step_pulse) ns++;
        end
        check("edge_r_blocked_cnt", nb, 5);
        check("edge_r_step_cnt", ns, 0);
        check("edge_r_hold", player_hPos, 628);

        // Walk left to zero, confirm no wrap.
        btns = 4'd1;
        n = 0;
        while (player_hPos != 10'd0 && n < 4000) begin
            tick(1);
            n++;
        end
        check("edge_l_reach", player_hPos, 0);
        nb = 0;
        ns = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (blocked_pulse) nb++;
            if (step_pulse) ns++;
        end
        check("edge_l_blocked_cnt", nb, 5);
        check("edge_l_step_cnt", ns, 0);
        check("edge_l_hold", player_hPos, 0);
        check("edge_l_vpos", player_vPos, 238);
        btns = 4'd0;
        tick(2);
        check("edge_idle", busy, 0);

        // Colour cycling; a held level advances only once.
        color_btn = 1'b1;
        tick(1);
        check("col_1", player_color, 1);
        tick(2);
        check("col_1_held", player_color, 1);
        color_btn = 1'b0;
        tick(1);
        color_btn = 1'b1;
        tick(1);
        check("col_2", player_color, 2);
        color_btn = 1'b0;
        tick(1);
        color_btn = 1'b1;
        tick(1);
        check("col_3", player_color, 3);
        color_btn = 1'b0;
        tick(1);
        color_btn = 1'b1;
        tick(1);
        check("col_wrap_0", player_color, 0);
        color_btn = 1'b0;
        tick(1);
        color_btn = 1'b1;
        tick(1);
        check("col_again_1", player_color, 1);
        color_btn = 1'b0;

        // Reset during WAIT with up held, then re-acceptance after release.
        btns = 4'd8;
        tick(2);
        check("rw_vpos", player_vPos, 237);
        tick(2);
        check("rw_busy_wait", busy, 1);
        rst = 1'b1;
        #1;
        check("rw_rst_hpos", player_hPos, 314);
        check("rw_rst_vpos", player_vPos, 234);
        check("rw_rst_color", player_color, 0);
        check("rw_rst_step", step_pulse, 0);
        check("rw_rst_blocked", blocked_pulse, 0);
        check("rw_rst_busy", busy, 0);
        tick(2);
        check("rw_hold_busy", busy, 0);
        rst = 1'b0;
        tick(1);
        check("rw_reaccept", busy, 1);
        tick(1);
        check("rw_step_vpos", player_vPos, 233);
        check("rw_step_pulse", step_pulse, 1);
        btns = 4'd0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
